// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception sequencer: FSM state type,
// CP0_CTRL pulse encodings and a small decode helper.
package exc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_ENTER  = 2'd2,
    S_RETURN = 2'd3
  } exc_state_t;

  localparam logic [1:0] CP0_EXL_SET = 2'b10;
  localparam logic [1:0] CP0_EXL_CLR = 2'b01;
  localparam logic [1:0] CP0_NOP     = 2'b00;

  // CP0_CTRL pulse for a state; only ENTER/RETURN ever touch EXL, so 2'b11 is unreachable.
  function automatic logic [1:0] ctrl_for_state(input exc_state_t st);
    logic [1:0] v;
    case (st)
      S_ENTER:  v = CP0_EXL_SET;
      S_RETURN: v = CP0_EXL_CLR;
      default:  v = CP0_NOP;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/exc_seq_ctrl.sv
// exc_seq_ctrl: sequences interrupt entry and ERET return for CP0.
// Interrupt entry waits for MEM-stage bus accesses to drain so EPC and the
// handler jump are precise. All outputs are registered and decoded from the
// state being entered, so they are Moore outputs of the current state.
// Optional feature macro: EXC_CNT_EN (adds the int_count port and counter).
module exc_seq_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic             id_valid,
  input  logic             id_eret,
  input  logic             mem_busy,
  input  logic [29:0]      cp0_epc,
  output logic [1:0]       cp0_ctrl,
  output logic             flush,
  output logic             hold_if,
  output logic             pc_redirect,
  output logic [29:0]      pc_target,
`ifdef EXC_CNT_EN
  output logic [CNT_W-1:0] int_count,
`endif
  output logic             exc_busy
);

  exc_state_t  r_state;
  exc_state_t  w_state_nxt;
  logic [29:0] w_target_nxt;
  logic [1:0]  r_cp0_ctrl;
  logic        r_flush;
  logic        r_hold_if;
  logic        r_pc_redirect;
  logic [29:0] r_pc_target;
  logic        r_exc_busy;

  // Next-state selection; ERET in ID outranks a simultaneous interrupt request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (id_valid && id_eret) begin
          w_state_nxt = S_RETURN;
        end else if (int_req && !mem_busy && id_valid) begin
          w_state_nxt = S_ENTER;
        end else if (int_req) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!int_req) begin
          w_state_nxt = S_IDLE;
        end else if (!mem_busy && id_valid) begin
          w_state_nxt = S_ENTER;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_ENTER:  w_state_nxt = S_IDLE;
      S_RETURN: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Redirect target for the state being entered; EPC is captured on entry to RETURN.
  always_comb begin
    w_target_nxt = 30'd0;
    case (w_state_nxt)
      S_ENTER:  w_target_nxt = HANDLER_ADDR[31:2];
      S_RETURN: w_target_nxt = cp0_epc;
      default:  w_target_nxt = 30'd0;
    endcase
  end

  // State register and registered output decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cp0_ctrl    <= CP0_NOP;
      r_flush       <= 1'b0;
      r_hold_if     <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= 30'd0;
      r_exc_busy    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cp0_ctrl    <= ctrl_for_state(w_state_nxt);
      r_flush       <= (w_state_nxt == S_ENTER) || (w_state_nxt == S_RETURN);
      r_hold_if     <= (w_state_nxt == S_DRAIN);
      r_pc_redirect <= (w_state_nxt == S_ENTER) || (w_state_nxt == S_RETURN);
      r_pc_target   <= w_target_nxt;
      r_exc_busy    <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef EXC_CNT_EN
  logic [CNT_W-1:0] r_int_count;

  // Interrupts-taken counter: advances as ENTER is entered, so it is visible during ENTER.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_int_count <= {CNT_W{1'b0}};
    end else if (w_state_nxt == S_ENTER) begin
      r_int_count <= r_int_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_int_count <= r_int_count;
    end
  end

  assign int_count = r_int_count;
`endif

  assign cp0_ctrl    = r_cp0_ctrl;
  assign flush       = r_flush;
  assign hold_if     = r_hold_if;
  assign pc_redirect = r_pc_redirect;
  assign pc_target   = r_pc_target;
  assign exc_busy    = r_exc_busy;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Self-checking bench for exc_seq_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the sequencing rules.
module tb_exc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, int_req, id_valid, id_eret, mem_busy;
  logic [29:0] cp0_epc;
  logic [1:0]  cp0_ctrl;
  logic        flush, hold_if, pc_redirect, exc_busy;
  logic [29:0] pc_target;
`ifdef EXC_CNT_EN
  logic [15:0] int_count;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: "draining" means an interrupt is waiting for the bus; pulse is the
  // one-cycle action being performed (0 none, 1 interrupt entry, 2 return).
  bit          m_drain;
  int          m_pulse;
  logic [29:0] m_ret_tgt;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  exc_seq_ctrl #(.HANDLER_ADDR(32'h0000_4180), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .id_valid(id_valid),
    .id_eret(id_eret), .mem_busy(mem_busy), .cp0_epc(cp0_epc),
    .cp0_ctrl(cp0_ctrl), .flush(flush), .hold_if(hold_if),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
`ifdef EXC_CNT_EN
    .int_count(int_count),
`endif
    .exc_busy(exc_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: what the sequencer must be doing in the next cycle.
  always @(posedge clk) begin
    if (!rst) begin
      m_drain <= 1'b0; m_pulse <= 0; m_ret_tgt <= 30'd0; m_cnt <= 16'd0;
    end else if (m_pulse != 0) begin
      m_pulse <= 0; m_drain <= 1'b0;
    end else if (m_drain) begin
      if (!int_req) m_drain <= 1'b0;
      else if (!mem_busy && id_valid) begin
        m_drain <= 1'b0; m_pulse <= 1; m_cnt <= m_cnt + 16'd1;
      end
    end else if (id_valid && id_eret) begin
      m_pulse <= 2; m_ret_tgt <= cp0_epc;
    end else if (int_req) begin
      if (!mem_busy && id_valid) begin
        m_pulse <= 1; m_cnt <= m_cnt + 16'd1;
      end else m_drain <= 1'b1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cp0_ctrl", {30'd0, cp0_ctrl},
          (m_pulse == 1) ? 32'd2 : (m_pulse == 2) ? 32'd1 : 32'd0);
      chk("flush", {31'd0, flush}, {31'd0, m_pulse != 0});
      chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, m_pulse != 0});
      chk("hold_if", {31'd0, hold_if}, {31'd0, m_drain});
      chk("exc_busy", {31'd0, exc_busy}, {31'd0, m_drain || (m_pulse != 0)});
      if (m_pulse == 1) chk("tgt_handler", {2'd0, pc_target}, 32'h0000_1060);
      if (m_pulse == 2) chk("tgt_epc", {2'd0, pc_target}, {2'd0, m_ret_tgt});
`ifdef EXC_CNT_EN
      chk("int_count", {16'd0, int_count}, {16'd0, m_cnt});
`endif
      chk("inv_no_11", {31'd0, cp0_ctrl != 2'b11}, 32'd1);
      chk("inv_hold_redir", {31'd0, hold_if && pc_redirect}, 32'd0);
    end
  end

  initial begin
    rst = 1'b0; int_req = 1'b1; id_valid = 1'b1; id_eret = 1'b0;
    mem_busy = 1'b0; cp0_epc = 30'd0;

    // Reset held 3 cycles with int_req asserted.
    tick(); chk_en = 1'b1;
    tick(); tick();
    chk("rst_busy", {31'd0, exc_busy}, 32'd0);
    chk("rst_ctrl", {30'd0, cp0_ctrl}, 32'd0);
    chk("rst_target", {2'd0, pc_target}, 32'd0);

    // First post-reset edge: qualified request goes straight to entry.
    rst = 1'b1; tick();
    chk("enter_ctrl", {30'd0, cp0_ctrl}, 32'd2);
    chk("enter_target", {2'd0, pc_target}, 32'h0000_1060);
    chk("enter_flush", {31'd0, flush}, 32'd1);
    int_req = 1'b0; tick();
    chk("enter_idle", {31'd0, exc_busy}, 32'd0);

    // Drain for 4 cycles, entry one cycle after mem_busy falls.
    int_req = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_hold", {31'd0, hold_if}, 32'd1);
    end
    mem_busy = 1'b0; tick();
    chk("drain_enter", {30'd0, cp0_ctrl}, 32'd2);
    chk("drain_hold_off", {31'd0, hold_if}, 32'd0);
    int_req = 1'b0; tick();

    // ERET beats simultaneous int_req.
    id_eret = 1'b1; cp0_epc = 30'h0C05; int_req = 1'b1; tick();
    chk("eret_ctrl", {30'd0, cp0_ctrl}, 32'd1);
    chk("eret_target", {2'd0, pc_target}, 32'h0000_0C05);
    id_eret = 1'b0; int_req = 1'b0; cp0_epc = 30'h3FFF_FFFF; tick();

    // Withdrawn request in DRAIN returns to idle with no pulse.
    int_req = 1'b1; mem_busy = 1'b1; tick();
    int_req = 1'b0; tick();
    chk("withdraw_busy", {31'd0, exc_busy}, 32'd0);
    chk("withdraw_redir", {31'd0, pc_redirect}, 32'd0);

    // Reset during DRAIN.
    int_req = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    chk("rst_drain_hold", {31'd0, hold_if}, 32'd0);
    rst = 1'b1; int_req = 1'b0; mem_busy = 1'b0; tick();

    // Three interrupts taken after reset.
    for (int i = 0; i < 3; i++) begin
      int_req = 1'b1; tick();
      int_req = 1'b0; tick();
    end
`ifdef EXC_CNT_EN
    chk("count_three", {16'd0, int_count}, 32'd3);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) != 0);
      int_req  = ($urandom_range(0, 2) != 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_eret  = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 1) != 0);
      cp0_epc  = 30'($urandom);
      tick();
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
